// File: rtl/cam_storage.sv
// CAM storage and search array: one-hot write enables from the index decoder,
// registered lowest-index associative search, registered indexed read with invalidate.
module cam_storage #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DEPTH-1:0]      write_enable_i,
   input  logic [WIDTH-1:0]      write_data_i,
   input  logic                  read_i,
   input  logic [ADDR_WIDTH-1:0] read_index_i,
   input  logic                  invalidate_i,
   output logic [WIDTH-1:0]      read_value_o,
   output logic                  read_valid_o,
   input  logic                  search_i,
   input  logic [WIDTH-1:0]      search_data_i,
   output logic                  search_valid_o,
   output logic [ADDR_WIDTH-1:0] search_index_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   count_o
);

   logic [WIDTH-1:0]      data_q [DEPTH];
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [DEPTH-1:0]      match;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] hit_index;
   logic [ADDR_WIDTH:0]   count_d;

   logic [WIDTH-1:0]      read_value_q;
   logic                  read_valid_q;
   logic                  search_valid_q;
   logic [ADDR_WIDTH-1:0] search_index_q;
   logic                  full_q;
   logic [ADDR_WIDTH:0]   count_q;

   // Invalidate is applied first so a same-cycle write to that entry wins.
   always_comb begin
      valid_d = valid_q;
      if (read_i && invalidate_i)
         valid_d[read_index_i] = 1'b0;
      valid_d = valid_d | write_enable_i;
   end

   always_comb begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++)
         count_d = count_d + (ADDR_WIDTH+1)'(valid_d[i]);
   end

   // Scanning downward leaves the lowest matching index selected.
   always_comb begin
      match     = '0;
      hit_index = '0;
      for (int i = 0; i < DEPTH; i++)
         match[i] = valid_q[i] && (data_q[i] == search_data_i);
      for (int i = DEPTH - 1; i >= 0; i--)
         if (match[i])
            hit_index = ADDR_WIDTH'(i);
      hit = |match;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            data_q[i] <= '0;
         valid_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (write_enable_i[i])
               data_q[i] <= write_data_i;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_value_q   <= '0;
         read_valid_q   <= 1'b0;
         search_valid_q <= 1'b0;
         search_index_q <= '0;
         full_q         <= 1'b0;
         count_q        <= '0;
      end else begin
         if (read_i) begin
            read_value_q <= data_q[read_index_i];
            read_valid_q <= valid_q[read_index_i];
         end else begin
            read_valid_q <= 1'b0;
         end
         if (search_i) begin
            search_valid_q <= hit;
            search_index_q <= hit_index;
         end else begin
            search_valid_q <= 1'b0;
         end
         full_q  <= &valid_d;
         count_q <= count_d;
      end
   end

   assign read_value_o   = read_value_q;
   assign read_valid_o   = read_valid_q;
   assign search_valid_o = search_valid_q;
   assign search_index_o = search_index_q;
   assign full_o         = full_q;
   assign count_o        = count_q;

endmodule
